// File: rtl/mod_reg16_ser.sv
// Block register that captures one 128-bit AES state and hands it to the
// downstream single-entry byte FIFO one byte at a time, most-significant byte first.
module mod_reg16_ser #(
  parameter int NBYTES = 16,
  parameter int BW     = 8,
  localparam int CW    = $clog2(NBYTES),
  localparam int DW    = NBYTES * BW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic          fifo_empty,
  output logic [BW-1:0] outp,
  output logic          empty,
  output logic [CW-1:0] byte_idx,
  output logic          done
);

  localparam int SW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, next_state;
  logic [DW-1:0] data;
  logic [CW-1:0] cnt;
  logic          load, xfer;
  logic [SW-1:0] shamt;
  logic [DW-1:0] shifted;

  // resetn is active-high despite its name
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && in_valid) begin
          load       = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        xfer = fifo_empty && !flush;
        if (flush || (xfer && cnt == LAST)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // flush wins over a simultaneous load or transfer
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      data <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (load) begin
        data <= in_data;
        cnt  <= '0;
      end else if (xfer) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign shamt    = SW'(cnt) * SW'(BW);
  assign shifted  = data << shamt;
  assign outp     = shifted[DW-1 -: BW];
  assign empty    = (state != SEND);
  assign in_ready = (state == IDLE) && !resetn;
  assign byte_idx = cnt;

endmodule

// File: tb/tb_mod_reg16_ser.sv
// Directed bench for mod_reg16_ser, including a small model of the downstream
// single-entry byte FIFO for the end-to-end ordering scenario.
module tb_mod_reg16_ser;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic         fifo_empty;
  logic         fifo_empty_drv;
  logic [7:0]   outp;
  logic         empty;
  logic [3:0]   byte_idx;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic       use_model = 1'b0;
  logic       rd_rom    = 1'b0;
  logic       fifo_full;
  logic [7:0] fifo_byte;
  logic [7:0] got[$];
  int         done_count;

  localparam logic [127:0] SEQ = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] AB  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

  mod_reg16_ser dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .fifo_empty(fifo_empty),
    .outp(outp), .empty(empty), .byte_idx(byte_idx), .done(done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = use_model ? ~fifo_full : fifo_empty_drv;

  // downstream FIFO: captures outp when empty and a byte is pending, pops on rd_rom
  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      fifo_full  <= 1'b0;
      fifo_byte  <= 8'h00;
      done_count <= 0;
    end else if (use_model) begin
      if (done) done_count <= done_count + 1;
      if (fifo_full) begin
        if (rd_rom) begin
          got.push_back(fifo_byte);
          fifo_full <= 1'b0;
        end
      end else if (!empty) begin
        fifo_byte <= outp;
        fifo_full <= 1'b1;
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] blk);
    in_data  = blk;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; fifo_empty_drv = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_outp", outp, 8'h00);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_byte_idx", byte_idx, 0);
    checkOutput("rst_done", done, 0);
    resetn = 1'b0;
    #1 checkOutput("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // full block, consumer always ready
    fifo_empty_drv = 1'b1;
    applyStimulus(SEQ);
    for (int i = 0; i < 16; i++) begin
      checkOutput("seq_outp", outp, i);
      checkOutput("seq_idx", byte_idx, i);
      checkOutput("seq_empty", empty, 0);
      checkOutput("seq_done_low", done, 0);
      @(negedge clk);
    end
    checkOutput("seq_done", done, 1);
    checkOutput("seq_end_empty", empty, 1);
    checkOutput("seq_end_ready", in_ready, 1);
    @(negedge clk);
    checkOutput("seq_done_pulse", done, 0);

    // stalled consumer
    fifo_empty_drv = 1'b0;
    applyStimulus(AB);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_outp", outp, 8'hA0);
      checkOutput("stall_idx", byte_idx, 0);
      checkOutput("stall_empty", empty, 0);
      @(negedge clk);
    end
    fifo_empty_drv = 1'b1;
    @(negedge clk);
    fifo_empty_drv = 1'b0;
    checkOutput("stall_step_outp", outp, 8'hA1);
    checkOutput("stall_step_idx", byte_idx, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("stall_flush_empty", empty, 1);
    checkOutput("stall_flush_done", done, 0);

    // flush in IDLE blocks a simultaneous load
    flush = 1'b1;
    applyStimulus(AB);
    flush = 1'b0;
    checkOutput("idle_flush_empty", empty, 1);

    // end-to-end with the downstream FIFO model
    use_model = 1'b1;
    applyStimulus(SEQ);
    for (int cyc = 0; cyc < 400 && got.size() < 16; cyc++) begin
      rd_rom = ((cyc / 3) % 2) == 1;
      @(negedge clk);
    end
    rd_rom = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("fifo_count", got.size(), 16);
    foreach (got[i]) checkOutput("fifo_byte", got[i], i);
    checkOutput("fifo_done_once", done_count, 1);
    checkOutput("fifo_end_empty", empty, 1);
    use_model = 1'b0;

    // flush at byte 7 together with a transfer
    fifo_empty_drv = 1'b1;
    applyStimulus(SEQ);
    repeat (7) @(negedge clk);
    checkOutput("fl_idx7", byte_idx, 7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fl_empty", empty, 1);
    checkOutput("fl_ready", in_ready, 1);
    checkOutput("fl_done", done, 0);
    fifo_empty_drv = 1'b0;
    applyStimulus({16{8'hFF}});
    checkOutput("fl_reload_idx", byte_idx, 0);
    checkOutput("fl_reload_outp", outp, 8'hFF);
    checkOutput("fl_reload_empty", empty, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // in_valid held during SEND is ignored, then loads after the bubble
    fifo_empty_drv = 1'b1;
    in_data = {16{8'h22}};
    in_valid = 1'b1;
    @(negedge clk);
    in_data = {16{8'h11}};
    for (int i = 0; i < 16; i++) begin
      checkOutput("hold_outp22", outp, 8'h22);
      checkOutput("hold_idx", byte_idx, i);
      @(negedge clk);
    end
    checkOutput("hold_done", done, 1);
    checkOutput("hold_bubble_empty", empty, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("hold_outp11", outp, 8'h11);
      checkOutput("hold_idx11", byte_idx, i);
      @(negedge clk);
    end
    checkOutput("hold_done11", done, 1);
    @(negedge clk);

    // async reset mid-block between edges
    applyStimulus(SEQ);
    repeat (9) @(negedge clk);
    checkOutput("ar_idx9", byte_idx, 9);
    #2 resetn = 1'b1;
    #1;
    checkOutput("ar_empty", empty, 1);
    checkOutput("ar_outp", outp, 8'h00);
    checkOutput("ar_ready", in_ready, 0);
    checkOutput("ar_idx", byte_idx, 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("ar_done_held", done, 0);
    end
    resetn = 1'b0;
    #1 checkOutput("ar_rel_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ar_rel_done", done, 0);
      checkOutput("ar_rel_empty", empty, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
